// File: rtl/usb_buffer_arbiter_pkg.sv
// Shared constants and types for the USB packet buffer arbiter: buffer size,
// register offsets, STATUS bit positions and FSM state encoding.
package usb_buffer_arbiter_pkg;

    localparam int USB_PACKET_BUFFER_SIZE = 1024;

    localparam int REG_STATUS     = 0;
    localparam int REG_WORD_COUNT = 1;

    localparam int STATUS_PACKET_READY = 0;
    localparam int STATUS_IRQ_ENABLE   = 1;
    localparam int STATUS_OVERRUN      = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RESPOND = 1'b1
    } state_t;

endpackage

// File: rtl/usb_buffer_arbiter.sv
// Arbitrates the single-port packet buffer RAM between the USB receiver (fixed
// priority, never stalled) and the CPU bus, and holds the receive status registers.
module usb_buffer_arbiter
    import usb_buffer_arbiter_pkg::*;
#(
    parameter int  USB_PACKET_BUFFER_SIZE = usb_buffer_arbiter_pkg::USB_PACKET_BUFFER_SIZE,
    localparam int AW = $clog2(USB_PACKET_BUFFER_SIZE / 4)
) (
    input  logic          clock48,
    input  logic          reset_n,
    input  logic [AW-1:0] usb_address,
    input  logic          usb_write,
    input  logic [31:0]   usb_write_value,
    input  logic          got_usb_packet,
    output logic          usb_packet_ready,
    output logic [31:0]   usb_read_value,
    input  logic          cpu_request,
    input  logic          cpu_write,
    input  logic [AW:0]   cpu_address,
    input  logic [31:0]   cpu_write_value,
    input  logic [3:0]    cpu_byte_enable,
    output logic          cpu_ready,
    output logic [31:0]   cpu_read_value,
    output logic [AW-1:0] ram_address,
    output logic          ram_write_enable,
    output logic [3:0]    ram_byte_enable,
    output logic [31:0]   ram_write_value,
    input  logic [31:0]   ram_read_value,
    output logic          usb_irq
);

    localparam logic [AW:0] WORDS_FULL = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic          irq_enable;
    logic          overrun;
    logic [AW:0]   words_written;
    logic          resp_from_ram;
    logic [31:0]   reg_read_q;
    logic [31:0]   reg_read_data;

    logic          accept;
    logic          reg_sel;
    logic [AW-1:0] reg_offset;
    logic          status_write;

    assign accept       = (state == IDLE) && cpu_request && !usb_write;
    assign reg_sel      = cpu_address[AW];
    assign reg_offset   = cpu_address[AW-1:0];
    assign status_write = accept && reg_sel && cpu_write && (reg_offset == AW'(REG_STATUS));

    assign usb_read_value = ram_read_value;
    assign usb_irq        = usb_packet_ready && irq_enable;
    assign cpu_read_value = cpu_ready ? (resp_from_ram ? ram_read_value : reg_read_q) : 32'h0;

    always_comb begin
        reg_read_data = 32'h0;
        if (reg_offset == AW'(REG_STATUS)) begin
            reg_read_data[STATUS_PACKET_READY] = usb_packet_ready;
            reg_read_data[STATUS_IRQ_ENABLE]   = irq_enable;
            reg_read_data[STATUS_OVERRUN]      = overrun;
        end else if (reg_offset == AW'(REG_WORD_COUNT)) begin
            reg_read_data = 32'(words_written);
        end
    end

    // USB always wins the port; the CPU only drives it in the cycle it is accepted.
    always_comb begin
        ram_address      = cpu_address[AW-1:0];
        ram_write_enable = 1'b0;
        ram_byte_enable  = 4'h0;
        ram_write_value  = 32'h0;
        if (usb_write) begin
            ram_address      = usb_address;
            ram_write_enable = 1'b1;
            ram_byte_enable  = 4'hF;
            ram_write_value  = usb_write_value;
        end else if (accept && !reg_sel) begin
            ram_write_enable = cpu_write;
            ram_byte_enable  = cpu_byte_enable;
            ram_write_value  = cpu_write_value;
        end
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cpu_ready     <= 1'b0;
            resp_from_ram <= 1'b0;
            reg_read_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    if (accept) begin
                        state         <= RESPOND;
                        cpu_ready     <= 1'b1;
                        resp_from_ram <= !reg_sel;
                        reg_read_q    <= reg_read_data;
                    end
                end
                RESPOND: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                end
            endcase
        end
    end

    // A packet arriving in the same cycle as a W1C clear keeps the flag set.
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            usb_packet_ready <= 1'b0;
            overrun          <= 1'b0;
            irq_enable       <= 1'b0;
        end else begin
            if (got_usb_packet)
                usb_packet_ready <= 1'b1;
            else if (status_write && cpu_write_value[STATUS_PACKET_READY])
                usb_packet_ready <= 1'b0;

            if (got_usb_packet && usb_packet_ready)
                overrun <= 1'b1;
            else if (status_write && cpu_write_value[STATUS_OVERRUN])
                overrun <= 1'b0;

            if (status_write)
                irq_enable <= cpu_write_value[STATUS_IRQ_ENABLE];
        end
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            words_written <= '0;
        end else if (usb_write) begin
            if (usb_address == '0)
                words_written <= (AW+1)'(1);
            else if (words_written != WORDS_FULL)
                words_written <= words_written + (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed self-checking bench for usb_buffer_arbiter with a behavioural
// synchronous byte-enabled RAM attached to the buffer port.
module tb_usb_buffer_arbiter;

    localparam int AW = 8;

    logic          clock48 = 1'b0;
    logic          reset_n;
    logic [AW-1:0] usb_address;
    logic          usb_write;
    logic [31:0]   usb_write_value;
    logic          got_usb_packet;
    logic          usb_packet_ready;
    logic [31:0]   usb_read_value;
    logic          cpu_request;
    logic          cpu_write;
    logic [AW:0]   cpu_address;
    logic [31:0]   cpu_write_value;
    logic [3:0]    cpu_byte_enable;
    logic          cpu_ready;
    logic [31:0]   cpu_read_value;
    logic [AW-1:0] ram_address;
    logic          ram_write_enable;
    logic [3:0]    ram_byte_enable;
    logic [31:0]   ram_write_value;
    logic [31:0]   ram_read_value;
    logic          usb_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];

    always #5 clock48 = ~clock48;

    usb_buffer_arbiter dut (
        .clock48          (clock48),
        .reset_n          (reset_n),
        .usb_address      (usb_address),
        .usb_write        (usb_write),
        .usb_write_value  (usb_write_value),
        .got_usb_packet   (got_usb_packet),
        .usb_packet_ready (usb_packet_ready),
        .usb_read_value   (usb_read_value),
        .cpu_request      (cpu_request),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .cpu_write_value  (cpu_write_value),
        .cpu_byte_enable  (cpu_byte_enable),
        .cpu_ready        (cpu_ready),
        .cpu_read_value   (cpu_read_value),
        .ram_address      (ram_address),
        .ram_write_enable (ram_write_enable),
        .ram_byte_enable  (ram_byte_enable),
        .ram_write_value  (ram_write_value),
        .ram_read_value   (ram_read_value),
        .usb_irq          (usb_irq)
    );

    // Buffer RAM: synchronous read returning the old word on a same-address write.
    always_ff @(posedge clock48) begin
        if (ram_write_enable)
            for (int b = 0; b < 4; b++)
                if (ram_byte_enable[b])
                    mem[ram_address][8*b +: 8] <= ram_write_value[8*b +: 8];
        ram_read_value <= mem[ram_address];
    end

    task automatic tick();
        @(posedge clock48);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
            $error("[TB] check %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic usbWrite(input logic [AW-1:0] addr, input logic [31:0] value);
        usb_address     = addr;
        usb_write_value = value;
        usb_write       = 1'b1;
        tick();
        usb_write       = 1'b0;
    endtask

    task automatic pulsePacket();
        got_usb_packet = 1'b1;
        tick();
        got_usb_packet = 1'b0;
    endtask

    // One CPU transaction; optionally pulses got_usb_packet in the acceptance cycle.
    task automatic applyStimulus(input logic wr, input logic [AW:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic got,
                                 output logic [31:0] rdata, output int latency);
        logic seen;
        seen            = 1'b0;
        rdata           = 32'h0;
        latency         = 0;
        cpu_write       = wr;
        cpu_address     = addr;
        cpu_write_value = wdata;
        cpu_byte_enable = be;
        cpu_request     = 1'b1;
        got_usb_packet  = got;
        for (int n = 1; n <= 8; n++) begin
            tick();
            got_usb_packet = 1'b0;
            if (cpu_ready) begin
                rdata   = cpu_read_value;
                latency = n;
                seen    = 1'b1;
                break;
            end
        end
        cpu_request = 1'b0;
        checkOutput("ready_seen", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic regRead(input int offset, output logic [31:0] rdata);
        int lat;
        applyStimulus(1'b0, {1'b1, AW'(offset)}, 32'h0, 4'h0, 1'b0, rdata, lat);
    endtask

    task automatic regWrite(input int offset, input logic [31:0] value, input logic got);
        logic [31:0] d;
        int lat;
        applyStimulus(1'b1, {1'b1, AW'(offset)}, value, 4'hF, got, d, lat);
    endtask

    task automatic bufRead(input int addr, output logic [31:0] rdata, output int lat);
        applyStimulus(1'b0, {1'b0, AW'(addr)}, 32'h0, 4'h0, 1'b0, rdata, lat);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        ready_glitch;

        reset_n         = 1'b0;
        usb_address     = '0;
        usb_write       = 1'b0;
        usb_write_value = 32'h0;
        got_usb_packet  = 1'b0;
        cpu_request     = 1'b0;
        cpu_write       = 1'b0;
        cpu_address     = '0;
        cpu_write_value = 32'h0;
        cpu_byte_enable = 4'h0;
        tick();
        tick();
        checkOutput("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("reset_cpu_read_value", cpu_read_value, 32'h0);
        checkOutput("reset_packet_ready", 32'(usb_packet_ready), 32'd0);
        checkOutput("reset_irq", 32'(usb_irq), 32'd0);
        reset_n = 1'b1;
        tick();
        regRead(0, rd);
        checkOutput("reset_status", rd, 32'h0);
        regRead(1, rd);
        checkOutput("reset_word_count", rd, 32'h0);

        // USB write drives the RAM port directly, then CPU reads it back
        usb_address     = 8'd5;
        usb_write_value = 32'hDEADBEEF;
        usb_write       = 1'b1;
        #1;
        checkOutput("usb_ram_address", 32'(ram_address), 32'd5);
        checkOutput("usb_ram_we", 32'(ram_write_enable), 32'd1);
        checkOutput("usb_ram_be", 32'(ram_byte_enable), 32'hF);
        checkOutput("usb_ram_wdata", ram_write_value, 32'hDEADBEEF);
        tick();
        usb_write = 1'b0;
        bufRead(5, rd, lat);
        checkOutput("buf_read_5", rd, 32'hDEADBEEF);
        checkOutput("buf_read_latency", 32'(lat), 32'd1);

        // CPU write collides with a USB write: USB first, CPU one cycle later
        usb_address     = 8'd3;
        usb_write_value = 32'hCAFEF00D;
        usb_write       = 1'b1;
        cpu_request     = 1'b1;
        cpu_write       = 1'b1;
        cpu_address     = 9'h007;
        cpu_write_value = 32'h12345678;
        cpu_byte_enable = 4'hF;
        #1;
        checkOutput("collide_ram_address_usb", 32'(ram_address), 32'd3);
        checkOutput("collide_ram_wdata_usb", ram_write_value, 32'hCAFEF00D);
        tick();
        usb_write = 1'b0;
        #1;
        checkOutput("collide_ram_address_cpu", 32'(ram_address), 32'd7);
        checkOutput("collide_ram_we_cpu", 32'(ram_write_enable), 32'd1);
        checkOutput("collide_ready_deferred", 32'(cpu_ready), 32'd0);
        tick();
        checkOutput("collide_ready", 32'(cpu_ready), 32'd1);
        cpu_request = 1'b0;
        tick();
        checkOutput("collide_ready_one_cycle", 32'(cpu_ready), 32'd0);
        bufRead(3, rd, lat);
        checkOutput("collide_word3", rd, 32'hCAFEF00D);
        bufRead(7, rd, lat);
        checkOutput("collide_word7", rd, 32'h12345678);

        // Packet of three words, then status, word count and interrupt
        usbWrite(8'd0, 32'h11223344);
        usbWrite(8'd1, 32'h01010101);
        usbWrite(8'd2, 32'h02020202);
        pulsePacket();
        regRead(1, rd);
        checkOutput("word_count_3", rd, 32'd3);
        regRead(0, rd);
        checkOutput("status_packet", rd, 32'h1);
        checkOutput("irq_disabled", 32'(usb_irq), 32'd0);
        regWrite(0, 32'h2, 1'b0);
        regRead(0, rd);
        checkOutput("status_irq_en", rd, 32'h3);
        checkOutput("irq_asserted", 32'(usb_irq), 32'd1);

        // Clear racing a new packet: set wins and overrun is flagged
        regWrite(0, 32'h1, 1'b1);
        regRead(0, rd);
        checkOutput("status_overrun", rd, 32'h5);
        checkOutput("irq_after_disable", 32'(usb_irq), 32'd0);
        regWrite(0, 32'h5, 1'b0);
        regRead(0, rd);
        checkOutput("status_cleared", rd, 32'h0);

        regWrite(3, 32'hFFFFFFFF, 1'b0);
        regRead(2, rd);
        checkOutput("unused_offset_reads_0", rd, 32'h0);
        regRead(0, rd);
        checkOutput("status_after_unused_write", rd, 32'h0);

        // Partial byte-lane write
        applyStimulus(1'b1, 9'h000, 32'h000000AA, 4'b0001, 1'b0, rd, lat);
        bufRead(0, rd, lat);
        checkOutput("byte_enable_merge", rd, 32'h112233AA);

        // Word counter saturates at 256
        usbWrite(8'd0, 32'h0);
        for (int i = 1; i <= 255; i++)
            usbWrite(AW'(i), 32'(i));
        regRead(1, rd);
        checkOutput("word_count_full", rd, 32'd256);
        usbWrite(8'd9, 32'h9);
        regRead(1, rd);
        checkOutput("word_count_saturated", rd, 32'd256);

        // Reset during RESPOND aborts the transaction
        regWrite(0, 32'h2, 1'b0);
        pulsePacket();
        cpu_write   = 1'b0;
        cpu_address = 9'h005;
        cpu_request = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(cpu_ready), 32'd0);
        checkOutput("abort_read_value", cpu_read_value, 32'h0);
        checkOutput("abort_packet_ready", 32'(usb_packet_ready), 32'd0);
        checkOutput("abort_irq", 32'(usb_irq), 32'd0);
        cpu_request = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        ready_glitch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ready) ready_glitch = 1'b1;
        end
        checkOutput("abort_no_late_ready", 32'(ready_glitch), 32'd0);
        regRead(0, rd);
        checkOutput("abort_status", rd, 32'h0);
        regRead(1, rd);
        checkOutput("abort_word_count", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
